// File: rtl/pulse_filt_pkg.sv
// pulse_filt_pkg
// Shared types and constant functions for the parametrised pulse-shaping FIR.
//   pf_mode_e : run-time filter selection (TX SRRC, RCV SRRC, bypass, boxcar)
//   lat()     : enable-count latency from a captured sample to its output
//   coef()    : unique-tap coefficient i (i = NH-1 is the centre tap), 2s(coef_w-2)
package pulse_filt_pkg;

    typedef enum logic [1:0] {
        MODE_TX  = 2'd0,
        MODE_RCV = 2'd1,
        MODE_BYP = 2'd2,
        MODE_BOX = 2'd3
    } pf_mode_e;

    // Stored SRRC tables are in 2s16 (18-bit) format, indexed by distance from centre.
    localparam int TBL_COEF_W = 18;
    localparam int TBL_LAST   = 10;

    function automatic int lat(input int ntaps);
        return 3 + $clog2((ntaps + 1) / 2);
    endfunction

    // TX shaper: SRRC, roll-off 0.25, 4 samples/symbol, scaled to unit energy.
    function automatic int srrc_tx(input int off);
        case (off)
            0:       return 35006;
            1:       return 30907;
            2:       return 20375;
            3:       return 7796;
            4:       return -2104;
            5:       return -6511;
            6:       return -5580;
            7:       return -1802;
            8:       return 1740;
            9:       return 3084;
            10:      return 2140;
            default: return 0;
        endcase
    endfunction

    // RCV matched filter: same SRRC shape, scaled to unit DC gain.
    function automatic int srrc_rcv(input int off);
        case (off)
            0:       return 16982;
            1:       return 14993;
            2:       return 9884;
            3:       return 3782;
            4:       return -1021;
            5:       return -3159;
            6:       return -2707;
            7:       return -874;
            8:       return 844;
            9:       return 1496;
            10:      return 1038;
            default: return 0;
        endcase
    endfunction

    // Lengths other than 21 keep the 4 samples/symbol spacing: the stored
    // response is truncated or zero-padded symmetrically about the centre.
    function automatic int coef(input pf_mode_e m, input int i, input int ntaps, input int coef_w);
        int nh;
        int off;
        int one;
        int base;
        nh   = (ntaps + 1) / 2;
        off  = nh - 1 - i;
        one  = 1 << (coef_w - 2);
        base = 0;
        case (m)
            MODE_BYP: return (off == 0) ? one : 0;
            MODE_BOX: return one;
            MODE_TX:  base = (off <= TBL_LAST) ? srrc_tx(off) : 0;
            default:  base = (off <= TBL_LAST) ? srrc_rcv(off) : 0;
        endcase
        if (coef_w >= TBL_COEF_W) begin
            return base <<< (coef_w - TBL_COEF_W);
        end
        return base >>> (TBL_COEF_W - coef_w);
    endfunction

endpackage

// File: rtl/pulse_filt_param_addtree.sv
// pulse_filt_addtree
// Registered binary adder tree: one register stage per tree level, so the sum
// of the N inputs appears ceil(log2(N)) enables after they were presented.
//   clk, reset : clock and synchronous active-high reset
//   en         : clock enable, the tree advances only when set
//   clr        : synchronous flush to zero (takes effect only with en)
//   din[N]     : signed operands, W bits
//   dout       : signed sum, W bits (caller provides headroom)
module pulse_filt_addtree #(
    parameter int N = 11,
    parameter int W = 42
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic signed [W-1:0] din [N],
    output logic signed [W-1:0] dout
);
    import pulse_filt_pkg::*;

    localparam int ST = $clog2(N);
    localparam int NP = 1 << ST;

    logic signed [W-1:0] pad   [NP];
    logic signed [W-1:0] sum_q [ST][NP/2];
    logic signed [W-1:0] sum_d [ST][NP/2];

    // Leaves beyond N are zero so every level is a full power of two.
    always_comb begin
        for (int j = 0; j < NP; j++) begin
            if (j < N) begin
                pad[j] = din[j];
            end else begin
                pad[j] = '0;
            end
        end
    end

    // Level s holds NP>>(s+1) partial sums; the rest of each row stays zero.
    always_comb begin
        for (int s = 0; s < ST; s++) begin
            for (int j = 0; j < NP/2; j++) begin
                sum_d[s][j] = '0;
            end
        end
        if (!en) begin
            sum_d = sum_q;
        end else if (!clr) begin
            for (int j = 0; j < NP/2; j++) begin
                sum_d[0][j] = pad[2*j] + pad[2*j+1];
            end
            for (int s = 1; s < ST; s++) begin
                for (int j = 0; j < (NP >> (s + 1)); j++) begin
                    sum_d[s][j] = sum_q[s-1][2*j] + sum_q[s-1][2*j+1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < ST; s++) begin
                for (int j = 0; j < NP/2; j++) begin
                    sum_q[s][j] <= '0;
                end
            end
        end else begin
            sum_q <= sum_d;
        end
    end

    assign dout = sum_q[ST-1][0];

endmodule

// File: rtl/pulse_filt_param.sv
// pulse_filt_param
// Odd-length symmetric FIR used as TX SRRC shaper, RCV matched filter,
// bypass or boxcar, on a 1s(DATA_W-1) sample stream advanced by sam_en.
// Pipeline: delay line -> pre-add of mirrored taps -> multiply -> registered
// adder tree -> round half up / saturate.
//   clk, reset : system clock, synchronous active-high reset
//   sam_en     : one-cycle sample enable
//   x_in       : signed input sample, captured on sam_en
//   mode       : 0 TX SRRC, 1 RCV SRRC, 2 bypass, 3 boxcar (sampled on sam_en)
//   y          : signed output, held between enables
//   y_valid    : pipeline primed for the current mode
//   sat_flag   : sticky output-saturation indicator
module pulse_filt_param
    import pulse_filt_pkg::*;
#(
    parameter int NTAPS  = 21,
    parameter int DATA_W = 18,
    parameter int COEF_W = 18,
    parameter int GUARD  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sam_en,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic        [1:0]        mode,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_valid,
    output logic                     sat_flag
);

    localparam int NH       = (NTAPS + 1) / 2;
    localparam int LAT      = lat(NTAPS);
    localparam int PRE_W    = DATA_W + 1;
    localparam int PROD_W   = PRE_W + COEF_W;
    localparam int ACC_W    = PROD_W + GUARD;
    localparam int FILL_MAX = NTAPS - 1 + LAT;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    localparam logic [FILL_W-1:0] FILL_MAX_C = FILL_W'(FILL_MAX);
    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-COEF_W+2){1'b0}}, 1'b1, {(COEF_W-3){1'b0}}};
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] dly_q [NTAPS];
    logic signed [DATA_W-1:0] dly_d [NTAPS];
    logic signed [PRE_W-1:0]  pre_q [NH];
    logic signed [PRE_W-1:0]  pre_d [NH];
    logic signed [PROD_W-1:0] mul_q [NH];
    logic signed [PROD_W-1:0] mul_d [NH];
    logic signed [COEF_W-1:0] coef_cur [NH];
    logic signed [ACC_W-1:0]  tree_in [NH];
    logic signed [ACC_W-1:0]  tree_out;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic                     sat_q, sat_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    pf_mode_e                 mode_q, mode_d;
    logic                     mode_chg;
    logic                     clamp_hi;
    logic                     clamp_lo;

    // A mode change is only recognised on an enable; that enable flushes
    // instead of capturing.
    assign mode_chg = sam_en && (pf_mode_e'(mode) != mode_q);

    // Coefficients follow the registered mode; the flush on a mode change
    // guarantees no stale samples meet the new coefficient set.
    always_comb begin
        for (int i = 0; i < NH; i++) begin
            coef_cur[i] = COEF_W'(coef(mode_q, i, NTAPS, COEF_W));
        end
    end

    always_comb begin
        for (int i = 0; i < NH; i++) begin
            tree_in[i] = ACC_W'(mul_q[i]);
        end
    end

    pulse_filt_addtree #(
        .N (NH),
        .W (ACC_W)
    ) u_addtree (
        .clk   (clk),
        .reset (reset),
        .en    (sam_en),
        .clr   (mode_chg),
        .din   (tree_in),
        .dout  (tree_out)
    );

    // Round half up: add half an output LSB, then drop the coefficient fraction.
    assign rnd      = (tree_out + RND_HALF) >>> (COEF_W - 2);
    assign clamp_hi = (rnd > Y_MAX);
    assign clamp_lo = (rnd < Y_MIN);

    always_comb begin
        dly_d  = dly_q;
        pre_d  = pre_q;
        mul_d  = mul_q;
        y_d    = y_q;
        sat_d  = sat_q;
        fill_d = fill_q;
        mode_d = mode_q;
        if (mode_chg) begin
            // y and sat_flag deliberately hold across the flush.
            mode_d = pf_mode_e'(mode);
            fill_d = '0;
            for (int i = 0; i < NTAPS; i++) begin
                dly_d[i] = '0;
            end
            for (int i = 0; i < NH; i++) begin
                pre_d[i] = '0;
                mul_d[i] = '0;
            end
        end else if (sam_en) begin
            dly_d[0] = x_in;
            for (int i = 1; i < NTAPS; i++) begin
                dly_d[i] = dly_q[i-1];
            end
            // Symmetric taps share one multiplier; the centre tap is unpaired.
            for (int i = 0; i < NH - 1; i++) begin
                pre_d[i] = PRE_W'(dly_q[i]) + PRE_W'(dly_q[NTAPS-1-i]);
            end
            pre_d[NH-1] = PRE_W'(dly_q[NH-1]);
            for (int i = 0; i < NH; i++) begin
                mul_d[i] = PROD_W'(pre_q[i]) * PROD_W'(coef_cur[i]);
            end
            if (clamp_hi) begin
                y_d = Y_MAX[DATA_W-1:0];
            end else if (clamp_lo) begin
                y_d = Y_MIN[DATA_W-1:0];
            end else begin
                y_d = rnd[DATA_W-1:0];
            end
            sat_d = sat_q | clamp_hi | clamp_lo;
            if (fill_q != FILL_MAX_C) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                dly_q[i] <= '0;
            end
            for (int i = 0; i < NH; i++) begin
                pre_q[i] <= '0;
                mul_q[i] <= '0;
            end
            y_q    <= '0;
            sat_q  <= 1'b0;
            fill_q <= '0;
            mode_q <= MODE_TX;
        end else begin
            dly_q  <= dly_d;
            pre_q  <= pre_d;
            mul_q  <= mul_d;
            y_q    <= y_d;
            sat_q  <= sat_d;
            fill_q <= fill_d;
            mode_q <= mode_d;
        end
    end

    assign y        = y_q;
    assign sat_flag = sat_q;
    assign y_valid  = (fill_q == FILL_MAX_C);

endmodule

// File: tb/tb_pulse_filt_param.sv
module tb_pulse_filt_param;

    localparam int LAT      = 7;
    localparam int FILL_MAX = 27;
    localparam int CASC_PK  = 35;

    typedef struct {
        int y;
        bit v;
        bit s;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               sam_en;
    logic signed [17:0] x_in;
    logic        [1:0]  mode;
    logic signed [17:0] y;
    logic               y_valid;
    logic               sat_flag;
    logic signed [17:0] y_b;
    logic               y_valid_b;
    logic               sat_b;

    int   n_vec  = 0;
    int   n_miss = 0;
    bit   started = 1'b0;
    bit   upd;
    exp_t sbq[$];
    exp_t last_exp = '{0, 1'b0, 1'b0};

    // Reference model state: samples captured since the last flush.
    int   xs[$];
    int   m_mode = 0;
    int   m_fill = 0;
    int   m_y    = 0;
    bit   m_sat  = 1'b0;

    // SRRC response by distance from the centre tap, in units of 2^-16.
    int tx_off[11]  = '{35006, 30907, 20375, 7796, -2104, -6511, -5580, -1802, 1740, 3084, 2140};
    int rcv_off[11] = '{16982, 14993, 9884, 3782, -1021, -3159, -2707, -874, 844, 1496, 1038};

    int casc_r[71];

    pulse_filt_param u_dut (
        .clk      (clk),
        .reset    (reset),
        .sam_en   (sam_en),
        .x_in     (x_in),
        .mode     (mode),
        .y        (y),
        .y_valid  (y_valid),
        .sat_flag (sat_flag)
    );

    // Second instance as RCV matched filter fed by the first.
    pulse_filt_param u_casc (
        .clk      (clk),
        .reset    (reset),
        .sam_en   (sam_en),
        .x_in     (y),
        .mode     (2'd1),
        .y        (y_b),
        .y_valid  (y_valid_b),
        .sat_flag (sat_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic signed [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int tap(input int m, input int j);
        int off;
        off = (j >= 10) ? j - 10 : 10 - j;
        case (m)
            0:       return tx_off[off];
            1:       return rcv_off[off];
            2:       return (off == 0) ? 65536 : 0;
            default: return 65536;
        endcase
    endfunction

    // y after the n-th capture is the convolution at capture n-LAT,
    // rounded half up to 2^-17 and clamped.
    task automatic modelStep(input bit rst, input bit en, input int x, input int m);
        exp_t   e;
        longint acc;
        longint r;
        int     t;
        if (rst) begin
            xs.delete();
            m_mode = 0;
            m_fill = 0;
            m_y    = 0;
            m_sat  = 1'b0;
        end else if (en) begin
            if (m != m_mode) begin
                m_mode = m;
                xs.delete();
                m_fill = 0;
            end else begin
                xs.push_back(x);
                if (m_fill < FILL_MAX) m_fill++;
                t   = xs.size() - 1 - LAT;
                acc = 0;
                for (int j = 0; j < 21; j++) begin
                    if (t - j >= 0) acc += longint'(tap(m_mode, j)) * longint'(xs[t-j]);
                end
                r = (acc + 32768) >>> 16;
                if (r > 131071) begin
                    r = 131071;
                    m_sat = 1'b1;
                end else if (r < -131072) begin
                    r = -131072;
                    m_sat = 1'b1;
                end
                m_y = int'(r);
            end
        end
        e.y = m_y;
        e.v = (m_fill == FILL_MAX);
        e.s = m_sat;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input int x, input int m);
        @(negedge clk);
        reset  = rst;
        sam_en = en;
        x_in   = 18'(x);
        mode   = 2'(m);
        if (rst || en) modelStep(rst, en, x, m);
    endtask

    task automatic checkOutput(input bit updated);
        if (updated) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL sb_underflow at %0t: got empty queue, expected an entry", $time);
            end else begin
                last_exp = sbq.pop_front();
            end
        end
        cmp(updated ? "y" : "y_hold", y, last_exp.y);
        cmp(updated ? "y_valid" : "y_valid_hold", {31'b0, y_valid}, int'(last_exp.v));
        cmp(updated ? "sat_flag" : "sat_flag_hold", {31'b0, sat_flag}, int'(last_exp.s));
    endtask

    // Monitor: pops an expectation on every edge where the DUT updates,
    // otherwise checks that the outputs hold.
    always @(posedge clk) begin
        upd = reset || sam_en;
        #1;
        if (started) checkOutput(upd);
    end

    initial begin
        #400000;
        $display("[TB] FAIL timeout at %0t: got no finish, expected finish", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int pk;
        int pk_abs;
        int a;
        reset  = 1'b1;
        sam_en = 1'b0;
        x_in   = '0;
        mode   = 2'd0;

        applyStimulus(1, 0, 0, 0);
        started = 1'b1;
        applyStimulus(1, 0, 0, 0);

        $display("[TB] bypass ramp, enable every 4th cycle");
        for (int k = 0; k < 45; k++) begin
            applyStimulus(0, 1, k, 2);
            for (int g = 0; g < 3; g++) applyStimulus(0, 0, k, 2);
        end

        $display("[TB] TX impulse");
        for (int k = 0; k < 30; k++) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, -131072, 0);
        for (int k = 0; k < 35; k++) applyStimulus(0, 1, 0, 0);

        $display("[TB] boxcar constants and saturation");
        for (int k = 0; k < 30; k++) applyStimulus(0, 1, 1000, 3);
        for (int k = 0; k < 30; k++) applyStimulus(0, 1, 131071, 3);
        for (int k = 0; k < 30; k++) applyStimulus(0, 1, -131072, 3);

        $display("[TB] hold with sam_en low, then reset over an enable");
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, int'($urandom_range(0, 200000)) - 100000, int'($urandom_range(0, 3)));
        applyStimulus(1, 1, 12345, 3);

        $display("[TB] random TX stream, switch to RCV mid-stream");
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 1, int'($urandom_range(0, 120000)) - 60000, 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) applyStimulus(0, 0, 0, 1);
        end
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 1, int'($urandom_range(0, 120000)) - 60000, 1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) applyStimulus(0, 0, 0, 0);
        end
        for (int k = 0; k < 30; k++) applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 131071, 1);
        for (int k = 0; k < 35; k++) applyStimulus(0, 1, 0, 1);

        $display("[TB] TX->RCV cascade symbol response");
        for (int k = 0; k < 60; k++) applyStimulus(0, 1, 0, 0);
        for (int k = 0; k <= 70; k++) begin
            applyStimulus(0, 1, (k == 0) ? 43690 : 0, 0);
            @(posedge clk);
            #2;
            casc_r[k] = int'(y_b);
            if (k == CASC_PK) cmp("casc_valid", {31'b0, y_valid_b}, 1);
        end
        pk = 0;
        pk_abs = 0;
        for (int k = 0; k <= 70; k++) begin
            a = (casc_r[k] < 0) ? -casc_r[k] : casc_r[k];
            if (a > pk_abs) begin
                pk_abs = a;
                pk = k;
            end
        end
        cmp("casc_peak_pos", pk, CASC_PK);
        for (int d = 1; d <= 30; d++) cmp("casc_symmetry", casc_r[CASC_PK-d], casc_r[CASC_PK+d]);
        $display("[TB] cascade stage sat_flag=%0b", sat_b);

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        @(posedge clk);
        #3;
        cmp("sb_drain", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
